// File: rtl/acc_cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, FSM states and ALU operations.
package acc_cpu_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_HALT  = 3'b000;
  localparam logic [OPC_W-1:0] OP_LOAD  = 3'b001;
  localparam logic [OPC_W-1:0] OP_STORE = 3'b010;
  localparam logic [OPC_W-1:0] OP_ADD   = 3'b011;
  localparam logic [OPC_W-1:0] OP_SUB   = 3'b100;
  localparam logic [OPC_W-1:0] OP_AND   = 3'b101;
  localparam logic [OPC_W-1:0] OP_JMP   = 3'b110;
  localparam logic [OPC_W-1:0] OP_JZ    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_PAUSE,
    S_HALTED
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_AND
  } alu_op_t;

  // Memory-read opcodes map onto ALU operations; everything else passes rdata through.
  function automatic alu_op_t alu_op_for(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD:  alu_op_for = ALU_ADD;
      OP_SUB:  alu_op_for = ALU_SUB;
      OP_AND:  alu_op_for = ALU_AND;
      default: alu_op_for = ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: pass/add/sub/and with zero, negative and
// signed-overflow indications for the result.
module acc_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 18
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y_c,
  output logic              n_c,
  output logic              z_c,
  output logic              v_c
);

  localparam int unsigned MSB = DATA_W - 1;

  always_comb begin
    y_c = '0;
    v_c = 1'b0;
    case (op)
      ALU_PASS: y_c = b;
      ALU_ADD: begin
        y_c = a + b;
        v_c = (a[MSB] == b[MSB]) && (y_c[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        y_c = a - b;
        v_c = (a[MSB] != b[MSB]) && (y_c[MSB] != a[MSB]);
      end
      ALU_AND: y_c = a & b;
      default: y_c = b;
    endcase
  end

  assign n_c = y_c[MSB];
  assign z_c = (y_c == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetch/decode/execute FSM with a req/ack memory port,
// run/step/halt control and debug taps of the architectural registers.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int unsigned       DATA_W   = 18,
  parameter int unsigned       ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic              halted,
  output logic              instr_done
);

  state_t            state;
  state_t            state_d;
  state_t            resume_state;
  logic [OPC_W-1:0]  op;
  logic [ADDR_W-1:0] opnd_addr;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] ir_d;
  logic [DATA_W-1:0] acc_d;
  logic              z_d;
  logic              n_d;
  logic              v_d;
  logic              retire;
  logic              ack;
  logic              req_d;
  logic              we_d;
  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_y;
  logic              alu_n;
  logic              alu_z;
  logic              alu_v;

  assign op           = ir[DATA_W-1 -: OPC_W];
  assign opnd_addr    = ir[ADDR_W-1:0];
  assign alu_op       = alu_op_for(op);
  // An ack only counts while a request is actually outstanding.
  assign ack          = mem_req & mem_ack;
  assign resume_state = step_mode ? S_PAUSE : S_FETCH;

  acc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op (alu_op),
    .a  (acc),
    .b  (mem_rdata),
    .y_c(alu_y),
    .n_c(alu_n),
    .z_c(alu_z),
    .v_c(alu_v)
  );

  // Next-state, register updates and next memory-port values.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ir_d       = ir;
    acc_d      = acc;
    z_d        = flag_z;
    n_d        = flag_n;
    v_d        = flag_v;
    retire     = 1'b0;
    req_d      = 1'b0;
    we_d       = 1'b0;
    mem_addr_d = mem_addr;

    case (state)
      S_IDLE: if (start) state_d = S_FETCH;

      S_FETCH: if (ack) begin
        ir_d    = mem_rdata;
        pc_d    = pc + ADDR_W'(1);
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (op)
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALTED;
          end
          OP_JMP: begin
            pc_d    = opnd_addr;
            retire  = 1'b1;
            state_d = resume_state;
          end
          OP_JZ: begin
            if (acc == '0) pc_d = opnd_addr;
            retire  = 1'b1;
            state_d = resume_state;
          end
          OP_STORE: state_d = S_MEM_WR;
          default:  state_d = S_MEM_RD;
        endcase
      end

      S_MEM_RD: if (ack) begin
        acc_d   = alu_y;
        z_d     = alu_z;
        n_d     = alu_n;
        v_d     = alu_v;
        retire  = 1'b1;
        state_d = resume_state;
      end

      S_MEM_WR: if (ack) begin
        retire  = 1'b1;
        state_d = resume_state;
      end

      S_PAUSE: if (step || !step_mode) state_d = S_FETCH;

      S_HALTED: if (start) state_d = S_FETCH;

      default: state_d = S_IDLE;
    endcase

    // The port is registered, so it is driven from the state being entered.
    if (state_d == S_FETCH) begin
      req_d      = 1'b1;
      mem_addr_d = pc_d;
    end else if (state_d == S_MEM_RD || state_d == S_MEM_WR) begin
      req_d      = 1'b1;
      we_d       = (state_d == S_MEM_WR);
      mem_addr_d = ir_d[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      acc        <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_v     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      ir         <= ir_d;
      acc        <= acc_d;
      flag_z     <= z_d;
      flag_n     <= n_d;
      flag_v     <= v_d;
      mem_req    <= req_d;
      mem_we     <= we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= acc_d;
      halted     <= (state_d == S_HALTED);
      instr_done <= retire;
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: table-driven ALU vectors plus hand-written
// programs for jumps, wrap, step mode, memory waits and mid-transaction reset.
module tb_acc_cpu_core;

  localparam logic [2:0] HALT = 3'b000, LOAD = 3'b001, STORE = 3'b010, ADD = 3'b011;
  localparam logic [2:0] SUB = 3'b100, AND = 3'b101, JMP = 3'b110, JZ = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [17:0] mem_wdata;
  logic [17:0] mem_rdata;
  logic        mem_ack;
  logic [12:0] pc;
  logic [17:0] ir;
  logic [17:0] acc;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
  logic        halted;
  logic        instr_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  acc_cpu_core #(
    .DATA_W  (18),
    .ADDR_W  (13),
    .RESET_PC(13'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .ir        (ir),
    .acc       (acc),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .halted    (halted),
    .instr_done(instr_done)
  );

  // Memory model with programmable ack latency; writes can be stalled indefinitely.
  logic [17:0] mem [0:8191];
  logic [15:0] wait_cnt  = 16'd0;
  logic [15:0] cur_delay = 16'd0;
  logic [15:0] eff_delay;
  logic        rand_mode = 1'b0;
  logic        stall_wr  = 1'b0;

  assign eff_delay = (stall_wr && mem_we) ? 16'hFFFF : cur_delay;
  assign mem_ack   = mem_req && (wait_cnt >= eff_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= 16'd0;
      cur_delay <= 16'd0;
    end else if (mem_req) begin
      if (mem_ack) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        wait_cnt  <= 16'd0;
        cur_delay <= rand_mode ? 16'($urandom_range(0, 5)) : 16'd0;
      end else begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

  // Request attributes must not move while a request waits for its ack.
  int          unstable = 0;
  logic        prev_wait = 1'b0;
  logic [12:0] p_addr;
  logic [17:0] p_wdata;
  logic        p_we;

  always @(posedge clk) begin
    if (reset && prev_wait &&
        (mem_req !== 1'b1 || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
      unstable <= unstable + 1;
    prev_wait <= reset && mem_req && !mem_ack;
    p_addr    <= mem_addr;
    p_we      <= mem_we;
    p_wdata   <= mem_wdata;
  end

  int done_cnt = 0;
  always @(negedge clk) if (instr_done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [2:0]  op;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] exp_acc;
    logic [2:0]  exp_znv;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [17:0] ins(input logic [2:0] op, input int unsigned opnd);
    return {op, 15'(opnd)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 18'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Pulse start, wait (bounded) for HALTED; returns cycles and retire count.
  task automatic run_prog(input string name, output int cycles, output int dones);
    int base;
    base  = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!halted && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_halted"}, 64'(halted), 64'd1);
    repeat (2) @(negedge clk);
    dones = done_cnt - base;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_done && n < 200);
    check({name, "_retire_seen"}, 64'(instr_done), 64'd1);
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[0]  = ins(LOAD, 10);
    mem[1]  = ins(ADD, 11);
    mem[2]  = ins(STORE, 12);
    mem[3]  = ins(HALT, 0);
    mem[10] = 18'd5;
    mem[11] = 18'd7;
  endtask

  int cyc;
  int dn;
  int req_seen;

  initial begin
    vecs[0] = '{ADD, 18'd5,     18'd7,     18'd12,    3'b000};
    vecs[1] = '{ADD, 18'h1FFFF, 18'd1,     18'h20000, 3'b011};
    vecs[2] = '{SUB, 18'd5,     18'd5,     18'd0,     3'b100};
    vecs[3] = '{SUB, 18'd0,     18'd1,     18'h3FFFF, 3'b010};
    vecs[4] = '{SUB, 18'h20000, 18'd1,     18'h1FFFF, 3'b001};
    vecs[5] = '{AND, 18'h3F0F0, 18'h0FF0F, 18'h0F000, 3'b000};
    vecs[6] = '{AND, 18'h2AAAA, 18'h15555, 18'd0,     3'b100};
    vecs[7] = '{ADD, 18'h20000, 18'h20000, 18'd0,     3'b101};
    vecs[8] = '{LOAD, 18'd5,    18'h30000, 18'h30000, 3'b010};

    reset = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_pc",  64'(pc), 64'd0);
    check("rst_ir",  64'(ir), 64'd0);
    check("rst_acc", 64'(acc), 64'd0);
    check("rst_flags", 64'({flag_z, flag_n, flag_v}), 64'd0);
    check("rst_port", 64'({mem_req, mem_we, mem_addr}), 64'd0);
    check("rst_status", 64'({halted, instr_done}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Program: LOAD 0x100; <op> 0x101; HALT.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      clear_mem();
      mem[0]     = ins(LOAD, 'h100);
      mem[1]     = ins(vecs[i].op, 'h101);
      mem[2]     = ins(HALT, 0);
      mem['h100] = vecs[i].a;
      mem['h101] = vecs[i].b;
      run_prog($sformatf("vec%0d", i), cyc, dn);
      check($sformatf("vec%0d_acc", i), 64'(acc), 64'(vecs[i].exp_acc));
      check($sformatf("vec%0d_znv", i), 64'({flag_z, flag_n, flag_v}), 64'(vecs[i].exp_znv));
      check($sformatf("vec%0d_pc", i), 64'(pc), 64'd3);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'd8);
    end

    // AND after an overflowing ADD clears flag_v.
    do_reset();
    clear_mem();
    mem[0] = ins(LOAD, 'h100); mem[1] = ins(ADD, 'h101); mem[2] = ins(AND, 'h102);
    mem['h100] = 18'h1FFFF; mem['h101] = 18'd1; mem['h102] = 18'h3FFFF;
    run_prog("and_clr_v", cyc, dn);
    check("and_clr_v_acc", 64'(acc), 64'h20000);
    check("and_clr_v_znv", 64'({flag_z, flag_n, flag_v}), 64'b010);

    // Main program, zero-wait, then resume from HALTED.
    do_reset();
    load_prog1();
    mem[4] = ins(LOAD, 11);
    mem[5] = ins(HALT, 0);
    run_prog("prog1", cyc, dn);
    check("prog1_mem12", 64'(mem[12]), 64'd12);
    check("prog1_pc", 64'(pc), 64'd4);
    check("prog1_dones", 64'(dn), 64'd4);
    check("prog1_cycles", 64'(cyc), 64'd11);
    run_prog("resume", cyc, dn);
    check("resume_acc", 64'(acc), 64'd7);
    check("resume_pc", 64'(pc), 64'd6);
    check("resume_cycles", 64'(cyc), 64'd5);
    check("resume_dones", 64'(dn), 64'd2);

    // Same program with random 0-5 cycle ack latency.
    do_reset();
    load_prog1();
    rand_mode = 1'b1;
    run_prog("rand", cyc, dn);
    rand_mode = 1'b0;
    check("rand_mem12", 64'(mem[12]), 64'd12);
    check("rand_acc", 64'(acc), 64'd12);
    check("rand_pc", 64'(pc), 64'd4);
    check("rand_dones", 64'(dn), 64'd4);

    // JZ taken with acc=0, not taken with acc=3.
    do_reset();
    clear_mem();
    mem[0] = ins(JZ, 'h20); mem[1] = ins(HALT, 0);
    mem['h20] = ins(LOAD, 'h100); mem['h21] = ins(JZ, 'h40); mem['h22] = ins(HALT, 0);
    mem['h40] = ins(HALT, 0); mem['h100] = 18'd3;
    run_prog("jz", cyc, dn);
    check("jz_pc", 64'(pc), 64'h23);
    check("jz_acc", 64'(acc), 64'd3);
    check("jz_cycles", 64'(cyc), 64'd9);

    // JMP to the last address; fetching it wraps pc to 0.
    do_reset();
    clear_mem();
    mem[0] = ins(JMP, 'h1FFF); mem['h1FFF] = ins(HALT, 0);
    run_prog("wrap", cyc, dn);
    check("wrap_pc", 64'(pc), 64'd0);
    check("wrap_cycles", 64'(cyc), 64'd4);

    // Step mode: pause after each retire until step, then drop to free run.
    do_reset();
    load_prog1();
    step_mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("step1");
    req_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    check("step1_noreq", 64'(req_seen), 64'd0);
    check("step1_acc", 64'(acc), 64'd5);
    check("step1_pc", 64'(pc), 64'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_done("step2");
    req_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    check("step2_noreq", 64'(req_seen), 64'd0);
    check("step2_acc", 64'(acc), 64'd12);
    check("step2_pc", 64'(pc), 64'd2);
    step_mode = 1'b0;
    cyc = 0;
    while (!halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("freerun_halted", 64'(halted), 64'd1);
    check("freerun_mem12", 64'(mem[12]), 64'd12);
    check("freerun_pc", 64'(pc), 64'd4);

    // Reset while a STORE waits for its ack.
    do_reset();
    load_prog1();
    stall_wr = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("stall_wr_seen", 64'({mem_req, mem_we}), 64'b11);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_req", 64'(mem_req), 64'd0);
    check("midrst_port", 64'({mem_we, mem_addr}), 64'd0);
    check("midrst_regs", 64'({pc, acc}), 64'd0);
    check("midrst_ir", 64'(ir), 64'd0);
    check("midrst_status", 64'({flag_z, flag_n, flag_v, halted, instr_done}), 64'd0);
    check("midrst_nowrite", 64'(mem[12]), 64'd0);
    stall_wr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_prog("after_rst", cyc, dn);
    check("after_rst_mem12", 64'(mem[12]), 64'd12);
    check("after_rst_pc", 64'(pc), 64'd4);
    check("after_rst_cycles", 64'(cyc), 64'd11);

    check("req_stable", 64'(unstable), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
